prom_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 32x8 program ROM (prom) in the SoC.
- Owns the program counter and drives the ROM address.
- Absorbs the ROM's one-cycle registered read latency.
- Delivers instructions to the decoder over a valid/ready handshake, with a 2-entry buffer for full throughput under backpressure.
- Handles start, branch redirect, halt-opcode detection and PC wrap-around.

---
 rtl/prom_fetch_ctrl_if.sv | 25 ++
 rtl/prom_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_prom_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prom_fetch_ctrl_if.sv
// Decoder-side instruction handshake between the fetch sequencer and the decoder.
// The fetch side (master) drives the instruction; the decoder (slave) drives ready.
interface prom_fetch_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/prom_fetch_ctrl.sv
// Instruction-fetch sequencer for the program ROM: owns the PC, hides the ROM's one-cycle
// read latency and feeds the decoder through a 2-entry buffer with redirect and halt support.
module prom_fetch_ctrl #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = '0,
    parameter bit                HALT_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    prom_fetch_ctrl_if.master  dec,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q;

    entry_t            buf_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    entry_t            head;

    logic              pop, halt_hit, redirect_hit, squash, push, issue;
    logic [1:0]        occupancy;

    assign head = buf_q[rd_ptr_q];

    // Handshake and control decisions for this cycle. Halt beats a same-cycle redirect.
    always_comb begin
        pop          = dec.instr_valid & dec.instr_ready;
        halt_hit     = HALT_EN && (state_q == ST_RUN) && pop && (head.data == HALT_WORD);
        redirect_hit = redirect && (state_q == ST_RUN) && !halt_hit;
        squash       = halt_hit | redirect_hit;
        push         = inflight_q & ~squash;
        // Words already held or on their way after this cycle's pop; one more may be issued
        // only if the buffer can still absorb it when it returns.
        occupancy    = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue        = (state_q == ST_RUN) && !squash && (occupancy < 2'd2);
    end

    // NOTE: combinational processes use blocking '=' and assign every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_HALT;
                end else if (redirect_hit) begin
                    pc_d = redirect_pc;
                end else if (issue) begin
                    inflight_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' with an asynchronous reset in the
    // sensitivity list, so every register sees pre-edge values and resets without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // Buffer bookkeeping; a squash empties it even when a pop completes in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (squash) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: buffer storage is deliberately not reset; count_q alone decides validity and
    // the outputs are forced to zero while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= '{data: rom_data, pc: inflight_pc_q};
        end
    end

    assign rom_addr        = pc_q;
    assign dec.instr_valid = (count_q != 2'd0);
    assign dec.instr       = dec.instr_valid ? head.data : '0;
    assign dec.instr_pc    = dec.instr_valid ? head.pc   : '0;
    assign busy            = (state_q == ST_RUN);
    assign halted          = (state_q == ST_HALT);

endmodule

// File: tb/tb_prom_fetch_ctrl.sv
// Bench for prom_fetch_ctrl: directed scenarios plus random handshake/redirect/start traffic,
// scored against a transfer-level model (expected next PC, ROM image, run/idle/halt state).
module tb_prom_fetch_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, ready, redirect;
    logic [AW-1:0] redirect_pc;
    logic          sel;

    logic [AW-1:0] rom_addr_h, rom_addr_nh;
    logic [DW-1:0] rom_data_h, rom_data_nh;
    logic          busy_h, busy_nh, halted_h, halted_nh;
    logic          start_h, start_nh;

    logic [DW-1:0] rom [32];

    prom_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dif_h ();
    prom_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dif_nh ();

    assign dif_h.instr_ready  = ready;
    assign dif_nh.instr_ready = ready;
    assign start_h            = start & ~sel;
    assign start_nh           = start & sel;

    prom_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(5'd0), .HALT_WORD(8'h00), .HALT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start_h), .rom_addr(rom_addr_h), .rom_data(rom_data_h),
        .dec(dif_h), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy_h), .halted(halted_h)
    );

    prom_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(5'd0), .HALT_WORD(8'h00), .HALT_EN(1'b0)) dut_nh (
        .clk(clk), .reset(reset), .start(start_nh), .rom_addr(rom_addr_nh), .rom_data(rom_data_nh),
        .dec(dif_nh), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy_nh), .halted(halted_nh)
    );

    always #5 clk = ~clk;

    // Registered program ROMs, one read per cycle.
    always @(posedge clk) begin
        rom_data_h  <= rom[rom_addr_h];
        rom_data_nh <= rom[rom_addr_nh];
    end

    logic [DW-1:0] o_instr;
    logic [AW-1:0] o_pc;
    logic          o_valid, o_busy, o_halted;

    always_comb begin
        o_instr  = sel ? dif_nh.instr       : dif_h.instr;
        o_pc     = sel ? dif_nh.instr_pc    : dif_h.instr_pc;
        o_valid  = sel ? dif_nh.instr_valid : dif_h.instr_valid;
        o_busy   = sel ? busy_nh            : busy_h;
        o_halted = sel ? halted_nh          : halted_h;
    end

    int            checks = 0;
    int            errors = 0;
    int            m_state;
    logic [AW-1:0] exp_pc;
    int            n_xfer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a negedge, drives inputs for the coming posedge, scores a transfer
    // against the model, advances the model, then checks the state seen after the edge.
    task automatic cycle(input bit rdy, input bit redir, input logic [AW-1:0] rpc, input bit st);
        bit            xfer, stall, halting;
        logic [DW-1:0] p_instr;
        logic [AW-1:0] p_pc;
        ready       = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        start       = st;
        xfer    = (o_valid === 1'b1) && rdy;
        stall   = (o_valid === 1'b1) && !rdy && !redir;
        halting = 1'b0;
        p_instr = o_instr;
        p_pc    = o_pc;
        if (xfer) begin
            check("xfer_pc", o_pc, exp_pc);
            check("xfer_data", o_instr, rom[exp_pc]);
            n_xfer++;
            if (!sel && rom[exp_pc] == 8'h00) halting = 1'b1;
            exp_pc = exp_pc + 5'd1;
        end
        if (halting) begin
            m_state = S_HALT;
        end else if (m_state == S_RUN && redir) begin
            exp_pc = rpc;
        end else if (m_state != S_RUN && st) begin
            m_state = S_RUN;
            exp_pc  = 5'd0;
        end
        @(negedge clk);
        start    = 1'b0;
        redirect = 1'b0;
        check("busy", o_busy, m_state == S_RUN);
        check("halted", o_halted, m_state == S_HALT);
        if (m_state != S_RUN) check("valid_off", o_valid, 0);
        if (stall) begin
            check("stall_valid", o_valid, 1);
            check("stall_instr", o_instr, p_instr);
            check("stall_pc", o_pc, p_pc);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            cyc;
        int            base;
        logic [AW-1:0] held_addr;

        for (int i = 0; i < 32; i++) rom[i] = 8'h80 | 8'(i);
        rom[0] = 8'hBF; rom[1] = 8'h5E; rom[2] = 8'hDA; rom[3] = 8'hBF;
        rom[4] = 8'h11; rom[5] = 8'h22; rom[6] = 8'h33; rom[7] = 8'h44;
        rom[8] = 8'h5B; rom[9] = 8'hDD; rom[10] = 8'h66; rom[11] = 8'h77;
        rom[12] = 8'hE0; rom[13] = 8'h00; rom[31] = 8'h00;

        sel = 1'b0; reset = 1'b1; start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_state = S_IDLE; exp_pc = '0; n_xfer = 0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_addr", rom_addr_h, 0);
        check("rst_instr", o_instr, 0);
        check("rst_pc", o_pc, 0);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_halted", o_halted, 0);
        reset = 1'b0;

        // Redirect is ignored while idle
        cycle(1, 1, 5'd9, 0);
        cycle(1, 0, 5'd0, 0);
        check("idle_redirect_addr", rom_addr_h, 0);

        // Start latency: valid first appears in cycle 3
        cycle(1, 0, 5'd0, 1);
        check("lat_c1_valid", o_valid, 0);
        check("lat_c1_addr", rom_addr_h, 0);
        cycle(1, 0, 5'd0, 0);
        check("lat_c2_valid", o_valid, 0);
        cycle(1, 0, 5'd0, 0);
        check("lat_c3_valid", o_valid, 1);
        check("lat_c3_pc", o_pc, 0);
        check("lat_c3_instr", o_instr, 8'hBF);

        // Full-rate stream up to and including the halt word at pc 13
        n_xfer = 0;
        cyc    = 0;
        while (m_state == S_RUN && cyc < 40) begin
            check("stream_valid", o_valid, 1);
            cycle(1, 0, 5'd0, 0);
            cyc++;
        end
        check("stream_count", n_xfer, 14);
        check("stream_cycles", cyc, 14);
        check("halt_flag", o_halted, 1);

        // Redirect while halted has no effect
        held_addr = rom_addr_h;
        cycle(1, 1, 5'd8, 0);
        cycle(1, 0, 5'd0, 0);
        check("halt_redirect_addr", rom_addr_h, held_addr);

        // Restart under backpressure
        cycle(0, 0, 5'd0, 1);
        cycle(0, 0, 5'd0, 0);
        check("rs_c2_valid", o_valid, 0);
        cycle(0, 0, 5'd0, 0);
        check("rs_c3_valid", o_valid, 1);
        check("rs_c3_instr", o_instr, 8'hBF);
        check("rs_c3_pc", o_pc, 0);
        repeat (5) begin
            cycle(0, 0, 5'd0, 0);
            check("stall_addr", rom_addr_h, 2);
        end

        // Release: back-to-back until pc 3 reaches the head
        for (int i = 0; i < 10; i++) begin
            if (o_valid === 1'b1 && o_pc == 5'd3) break;
            check("bp_valid", o_valid, 1);
            cycle(1, 0, 5'd0, 0);
        end
        check("head_pc3", o_pc, 3);

        // Redirect to 8 in the same cycle pc 3 transfers
        cycle(1, 1, 5'd8, 0);
        check("rd_r0_valid", o_valid, 0);
        cycle(1, 0, 5'd0, 0);
        check("rd_r1_valid", o_valid, 0);
        cycle(1, 0, 5'd0, 0);
        check("rd_r2_valid", o_valid, 1);
        check("rd_target_pc", o_pc, 8);
        check("rd_target_instr", o_instr, 8'h5B);
        cycle(1, 0, 5'd0, 0);
        check("rd_next_pc", o_pc, 9);
        check("rd_next_instr", o_instr, 8'hDD);

        // Random traffic: ready, redirects, stray starts
        base = n_xfer;
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  AW'($urandom_range(0, 31)), $urandom_range(0, 7) == 0);
        end
        check("rand_progress", (n_xfer - base) > 20, 1);

        // Reset mid-stream at pc 6
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_state = S_IDLE; exp_pc = '0;
        cycle(1, 0, 5'd0, 1);
        for (int i = 0; i < 20; i++) begin
            if (o_valid === 1'b1 && o_pc == 5'd6) break;
            cycle(1, 0, 5'd0, 0);
        end
        check("mid_head_pc6", o_pc, 6);
        reset = 1'b1;
        #1;
        check("mr_instr", o_instr, 0);
        check("mr_pc", o_pc, 0);
        check("mr_valid", o_valid, 0);
        check("mr_busy", o_busy, 0);
        check("mr_halted", o_halted, 0);
        check("mr_addr", rom_addr_h, 0);
        m_state = S_IDLE; exp_pc = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) cycle(1, 0, 5'd0, 0);
        cycle(1, 0, 5'd0, 1);
        cycle(1, 0, 5'd0, 0);
        cycle(1, 0, 5'd0, 0);
        check("mr_restart_valid", o_valid, 1);
        check("mr_restart_pc", o_pc, 0);
        check("mr_restart_instr", o_instr, 8'hBF);

        // Wrap-around on the instance with halt detection disabled
        sel = 1'b1;
        m_state = S_IDLE; exp_pc = '0;
        cycle(1, 0, 5'd0, 1);
        cycle(1, 0, 5'd0, 0);
        cycle(1, 0, 5'd0, 0);
        check("wr_first_pc", o_pc, 0);
        cycle(1, 1, 5'd31, 0);
        cycle(1, 0, 5'd0, 0);
        cycle(1, 0, 5'd0, 0);
        check("wr_head_pc", o_pc, 31);
        check("wr_head_instr", o_instr, 8'h00);
        base = n_xfer;
        for (int i = 0; i < 10; i++) begin
            if (n_xfer - base >= 3) break;
            cycle(1, 0, 5'd0, 0);
        end
        check("wr_count", n_xfer - base, 3);
        check("wr_not_halted", o_halted, 0);
        check("wr_next_pc", o_pc, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
